buffer_display_scan: RTL

- Downstream consumer of the LRU value buffer. Takes its flattened entry array and presence mask and shows each present entry in turn on the board's multiplexed 8-digit seven-segment display.
- Auto-advances after a dwell period; a pulse input forces an immediate advance.
- Snapshots each entry's value when it is selected, so the display never tears while the buffer updates.

---
 rtl/display_pkg.sv | 55 +++++
 rtl/buffer_display_scan_hex7seg.sv | 34 +++
 rtl/buffer_display_scan.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and helpers for the buffer display scanner.
//   state_e      : scanner FSM states
//   SEG_*        : active-low seven-segment font (bit0=a .. bit6=g)
//   next_present : next set mask bit strictly after cur, wrapping modulo size
package display_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

  localparam int unsigned MAX_BUF_SIZE = 16;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  // Scan cur+1, cur+2, ... (mod size); returns cur itself if it is the only
  // set bit, or if no bit is set at all. Passing cur=size-1 yields the lowest
  // present index.
  function automatic logic [3:0] next_present(input logic [15:0]   mask,
                                              input logic [3:0]    cur,
                                              input int unsigned   size);
    logic [3:0]  res;
    logic        found;
    int unsigned idx;
    res   = cur;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_BUF_SIZE; i++) begin
      if (!found && (i <= size)) begin
        idx = (32'(cur) + i) % size;
        if (mask[idx[3:0]]) begin
          res   = 4'(idx);
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/buffer_display_scan_hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
//   nibble : 4-bit value to display
//   seg_c  : segment pattern, bit0=a .. bit6=g, active-low
module hex7seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (nibble)
      4'h0: seg_c = SEG_0;
      4'h1: seg_c = SEG_1;
      4'h2: seg_c = SEG_2;
      4'h3: seg_c = SEG_3;
      4'h4: seg_c = SEG_4;
      4'h5: seg_c = SEG_5;
      4'h6: seg_c = SEG_6;
      4'h7: seg_c = SEG_7;
      4'h8: seg_c = SEG_8;
      4'h9: seg_c = SEG_9;
      4'hA: seg_c = SEG_A;
      4'hB: seg_c = SEG_B;
      4'hC: seg_c = SEG_C;
      4'hD: seg_c = SEG_D;
      4'hE: seg_c = SEG_E;
      4'hF: seg_c = SEG_F;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/buffer_display_scan.sv
// Cycles through the present entries of the LRU value buffer and shows each
// on a multiplexed seven-segment display.
//   clk_i, rst_ni     : clock, async active-low reset
//   buf_array_i       : flattened entries, entry i at [i*BUF_WIDTH +: BUF_WIDTH]
//   buf_pres_array_i  : entry-valid mask
//   step_i            : one-cycle forced advance
//   seg_o, dp_o, an_o : active-low segments, decimal point, one-hot anodes
//   cur_idx_o         : index being shown
//   valid_o           : high while an entry is shown
module buffer_display_scan
  import display_pkg::*;
#(
  parameter int unsigned BUF_WIDTH      = 16,
  parameter int unsigned BUF_SIZE       = 8,
  parameter int unsigned DIGITS         = 8,
  parameter int unsigned DWELL_CYCLES   = 50_000_000,
  parameter int unsigned REFRESH_CYCLES = 100_000,
  localparam int unsigned IDX_W = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [BUF_SIZE*BUF_WIDTH-1:0] buf_array_i,
  input  logic [BUF_SIZE-1:0]           buf_pres_array_i,
  input  logic                          step_i,
  output logic [6:0]                    seg_o,
  output logic                          dp_o,
  output logic [DIGITS-1:0]             an_o,
  output logic [IDX_W-1:0]              cur_idx_o,
  output logic                          valid_o
);

  localparam int unsigned NIBBLES = BUF_WIDTH / 4;
  localparam int unsigned DIG_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int unsigned REF_W   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [BUF_WIDTH-1:0] snap_q, snap_d;
  logic [REF_W-1:0]     ref_q;
  logic [DIG_W-1:0]     dig_q;
  logic [6:0]           seg_q;
  logic                 dp_q;
  logic [DIGITS-1:0]    an_q;

  logic [15:0]          mask16_c;
  logic [3:0]           sel_c;
  logic [BUF_WIDTH-1:0] sel_entry_c;
  logic                 dwell_tc_c;
  logic [3:0]           nibble_c;
  logic [6:0]           font_c;

  assign mask16_c   = 16'(buf_pres_array_i);
  assign dwell_tc_c = (dwell_q == DWELL_W'(DWELL_CYCLES - 1));

  // In IDLE search from the top so the lowest present index is found.
  always_comb begin
    if (state_q == IDLE) sel_c = next_present(mask16_c, 4'(BUF_SIZE - 1), BUF_SIZE);
    else                 sel_c = next_present(mask16_c, 4'(ptr_q), BUF_SIZE);
  end

  always_comb begin
    sel_entry_c = '0;
    for (int unsigned i = 0; i < BUF_SIZE; i++) begin
      if (sel_c == 4'(i)) sel_entry_c = buf_array_i[i*BUF_WIDTH +: BUF_WIDTH];
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      dwell_q <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dwell_q <= dwell_d;
      snap_q  <= snap_d;
    end
  end

  // FSM next state: selection, dwell timing, snapshot load
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    dwell_d = dwell_q;
    snap_d  = snap_q;
    case (state_q)
      IDLE: begin
        if (|buf_pres_array_i) begin
          state_d = SHOW;
          ptr_d   = IDX_W'(sel_c);
          snap_d  = sel_entry_c;
          dwell_d = '0;
        end
      end
      SHOW: begin
        if (!(|buf_pres_array_i)) begin
          state_d = IDLE;
          dwell_d = '0;
        end else if (!buf_pres_array_i[ptr_q] || dwell_tc_c || step_i) begin
          ptr_d   = IDX_W'(sel_c);
          snap_d  = sel_entry_c;
          dwell_d = '0;
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Free-running digit scan
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ref_q <= '0;
      dig_q <= '0;
    end else if (ref_q == REF_W'(REFRESH_CYCLES - 1)) begin
      ref_q <= '0;
      dig_q <= (dig_q == DIG_W'(DIGITS - 1)) ? '0 : dig_q + DIG_W'(1);
    end else begin
      ref_q <= ref_q + REF_W'(1);
    end
  end

  // Nibble for the current digit; the top digit shows the index.
  always_comb begin
    nibble_c = 4'(ptr_d);
    for (int unsigned k = 0; k < NIBBLES; k++) begin
      if (dig_q == DIG_W'(k)) nibble_c = snap_d[4*k +: 4];
    end
  end

  hex7seg u_hex7seg (
    .nibble (nibble_c),
    .seg_c  (font_c)
  );

  // Pins follow the post-edge selection so blanking and entry changes land
  // together with cur_idx_o/valid_o; the digit index adds one cycle of lag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      an_q  <= '1;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= '1;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
      if (state_d == SHOW) begin
        if (32'(dig_q) < NIBBLES) begin
          an_q  <= ~(DIGITS'(1) << dig_q);
          seg_q <= font_c;
        end else if (32'(dig_q) == DIGITS - 1) begin
          an_q  <= ~(DIGITS'(1) << dig_q);
          seg_q <= font_c;
          dp_q  <= 1'b0;
        end
      end
    end
  end

  assign seg_o     = seg_q;
  assign dp_o      = dp_q;
  assign an_o      = an_q;
  assign cur_idx_o = ptr_q;
  assign valid_o   = (state_q == SHOW);

endmodule
